// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Holds the controller state encoding, register-index width and the x0 index.
package hazard_pkg;

    localparam logic RUN  = 1'b0;
    localparam logic WAIT = 1'b1;

    localparam int REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] X0 = 5'd0;

    // Wide enough for the largest legal MEM_TIMEOUT (255).
    localparam int WAIT_CNT_W = 8;

    typedef enum logic {
        ST_RUN  = RUN,
        ST_WAIT = WAIT
    } state_e;

endpackage

// File: rtl/hazard_load_use_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the register
// a load in EX is about to write. Purely combinational.
// Ports:
//   id_rs1_i, id_rs2_i       source indices of the ID instruction
//   id_uses_rs1_i/_rs2_i     ID instruction actually reads that source
//   ex_rd_i                  destination of the EX instruction
//   ex_mem_read_i            EX instruction is a load
//   lu_hazard_o              a bubble is required
module hazard_load_use_detect
    import hazard_pkg::*;
(
    input  logic [REG_IDX_W-1:0] id_rs1_i,
    input  logic [REG_IDX_W-1:0] id_rs2_i,
    input  logic                 id_uses_rs1_i,
    input  logic                 id_uses_rs2_i,
    input  logic [REG_IDX_W-1:0] ex_rd_i,
    input  logic                 ex_mem_read_i,
    output logic                 lu_hazard_o
);

    logic rs1_match;
    logic rs2_match;

    assign rs1_match = id_uses_rs1_i && (id_rs1_i == ex_rd_i);
    assign rs2_match = id_uses_rs2_i && (id_rs2_i == ex_rd_i);

    // A load into x0 never produces a value, so it cannot create a hazard.
    assign lu_hazard_o = ex_mem_read_i && (ex_rd_i != X0) && (rs1_match || rs2_match);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core.
// Issues PC/IF-ID enables, per-stage flushes and a global hold in response to
// load-use hazards, taken branches resolved in MEM, and multi-cycle data
// memory accesses (with a timeout that abandons a stuck access).
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   id_rs1, id_rs2, id_uses_rs1/2   ID instruction source operands
//   ex_rd, ex_MemRead               EX instruction destination / load flag
//   mem_Branch, mem_zero            MEM-stage branch resolution
//   dmem_req, dmem_ready            MEM-stage data memory handshake
//   pc_enable, pc_sel_branch        PC update control
//   if_id_enable, if_id_flush       IF/ID register control
//   id_ex_flush, ex_mem_flush       bubble insertion for later stages
//   pipe_hold                       freeze ID/EX, EX/MEM, MEM/WB
//   mem_timeout                     sticky: an access was abandoned
//   stall_cycles, flush_events      saturating performance counters
//
// state   | meaning
// RUN     | pipeline flowing, no memory access outstanding
// WAIT    | frozen on an outstanding data-memory access, wait_cnt counting
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_MemRead,
    input  logic                 mem_Branch,
    input  logic                 mem_zero,
    input  logic                 dmem_req,
    input  logic                 dmem_ready,
    output logic                 pc_enable,
    output logic                 pc_sel_branch,
    output logic                 if_id_enable,
    output logic                 if_id_flush,
    output logic                 id_ex_flush,
    output logic                 ex_mem_flush,
    output logic                 pipe_hold,
    output logic                 mem_timeout,
    output logic [CNT_W-1:0]     stall_cycles,
    output logic [CNT_W-1:0]     flush_events
);

    localparam logic [WAIT_CNT_W-1:0] TMO_LAST = WAIT_CNT_W'(MEM_TIMEOUT - 1);

    state_e                  state_q, state_d;
    logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                    mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0]        stall_q, stall_d;
    logic [CNT_W-1:0]        flush_q, flush_d;

    logic lu_hazard;
    logic br_taken;
    logic force_release;
    logic mem_wait;

    hazard_load_use_detect u_lu_detect (
        .id_rs1_i      (id_rs1),
        .id_rs2_i      (id_rs2),
        .id_uses_rs1_i (id_uses_rs1),
        .id_uses_rs2_i (id_uses_rs2),
        .ex_rd_i       (ex_rd),
        .ex_mem_read_i (ex_MemRead),
        .lu_hazard_o   (lu_hazard)
    );

    assign br_taken      = mem_Branch && mem_zero;
    // On the last allowed wait cycle the access is dropped and the pipe moves on.
    assign force_release = (state_q == ST_WAIT) && (wait_cnt_q == TMO_LAST) && !dmem_ready;
    assign mem_wait      = dmem_req && !dmem_ready && !force_release;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
            stall_q       <= '0;
            flush_q       <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            stall_q       <= stall_d;
            flush_q       <= flush_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q | force_release;

        case (state_q)
            ST_RUN: begin
                if (mem_wait) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = WAIT_CNT_W'(1);
                end else begin
                    wait_cnt_d = '0;
                end
            end
            ST_WAIT: begin
                if (force_release || !mem_wait) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
                end
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Counters: a branch overrides a coincident load-use stall, and a memory
    // freeze masks a coincident branch (it is re-seen after the unfreeze).
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if ((mem_wait || (lu_hazard && !br_taken)) && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
        if (br_taken && !mem_wait && (flush_q != '1)) begin
            flush_d = flush_q + CNT_W'(1);
        end
    end

    always_comb begin
        pc_enable     = 1'b0;
        pc_sel_branch = 1'b0;
        if_id_enable  = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_flush  = 1'b0;
        pipe_hold     = 1'b0;
        if (!rst) begin
            if (mem_wait) begin
                pipe_hold = 1'b1;
            end else if (br_taken) begin
                pc_enable     = 1'b1;
                pc_sel_branch = 1'b1;
                if_id_enable  = 1'b1;
                if_id_flush   = 1'b1;
                id_ex_flush   = 1'b1;
                ex_mem_flush  = 1'b1;
            end else if (lu_hazard) begin
                id_ex_flush = 1'b1;
            end else begin
                pc_enable    = 1'b1;
                if_id_enable = 1'b1;
            end
        end
    end

    assign mem_timeout  = mem_timeout_q;
    assign stall_cycles = stall_q;
    assign flush_events = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4).
module tb_hazard_ctrl;

    localparam int MT = 4;
    localparam int CW = 4;

    logic          clk, rst;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          id_uses_rs1, id_uses_rs2, ex_MemRead;
    logic          mem_Branch, mem_zero, dmem_req, dmem_ready;
    logic          pc_enable, pc_sel_branch, if_id_enable, if_id_flush;
    logic          id_ex_flush, ex_mem_flush, pipe_hold, mem_timeout;
    logic [CW-1:0] stall_cycles, flush_events;

    hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_uses_rs1   (id_uses_rs1),
        .id_uses_rs2   (id_uses_rs2),
        .ex_rd         (ex_rd),
        .ex_MemRead    (ex_MemRead),
        .mem_Branch    (mem_Branch),
        .mem_zero      (mem_zero),
        .dmem_req      (dmem_req),
        .dmem_ready    (dmem_ready),
        .pc_enable     (pc_enable),
        .pc_sel_branch (pc_sel_branch),
        .if_id_enable  (if_id_enable),
        .if_id_flush   (if_id_flush),
        .id_ex_flush   (id_ex_flush),
        .ex_mem_flush  (ex_mem_flush),
        .pipe_hold     (pipe_hold),
        .mem_timeout   (mem_timeout),
        .stall_cycles  (stall_cycles),
        .flush_events  (flush_events)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctl = {pc_enable, pc_sel_branch, if_id_enable, if_id_flush, id_ex_flush, ex_mem_flush, pipe_hold}
    localparam logic [6:0] CTL_NONE   = 7'b1010000;
    localparam logic [6:0] CTL_BRANCH = 7'b1111110;
    localparam logic [6:0] CTL_LU     = 7'b0000100;
    localparam logic [6:0] CTL_HOLD   = 7'b0000001;

    typedef struct {
        logic [6:0] ctl;
        int         stall;
        int         flush;
        logic       tmo;
    } exp_t;

    exp_t exp_q[$];

    int n_chk = 0;
    int n_err = 0;

    // reference model state
    bit m_wait;
    int m_cnt, m_stall, m_flush;
    bit m_tmo;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] dut_ctl();
        return {pc_enable, pc_sel_branch, if_id_enable, if_id_flush, id_ex_flush, ex_mem_flush, pipe_hold};
    endfunction

    task automatic model_reset();
        m_wait = 0; m_cnt = 0; m_stall = 0; m_flush = 0; m_tmo = 0;
    endtask

    task automatic zero_inputs();
        id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        ex_rd = 0; ex_MemRead = 0; mem_Branch = 0; mem_zero = 0;
        dmem_req = 0; dmem_ready = 0;
    endtask

    // One clock of stimulus: drive, predict, push; sample mid-cycle, pop, compare.
    task automatic step(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                        input logic [4:0] rd, input logic mr, input logic br, input logic z,
                        input logic req, input logic rdy);
        bit   fr, mw, brt, lu;
        exp_t e, g;
        @(posedge clk);
        #1;
        id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
        ex_rd = rd; ex_MemRead = mr; mem_Branch = br; mem_zero = z;
        dmem_req = req; dmem_ready = rdy;

        fr  = m_wait && (m_cnt == MT - 1) && !rdy;
        mw  = req && !rdy && !fr;
        brt = br && z;
        lu  = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        if (mw)       e.ctl = CTL_HOLD;
        else if (brt) e.ctl = CTL_BRANCH;
        else if (lu)  e.ctl = CTL_LU;
        else          e.ctl = CTL_NONE;
        e.stall = m_stall;
        e.flush = m_flush;
        e.tmo   = m_tmo;
        exp_q.push_back(e);

        @(negedge clk);
        if (exp_q.size() == 0) begin
            chk("q_empty", 32'd0, 32'd1);
        end else begin
            g = exp_q.pop_front();
            chk("ctl",   32'(dut_ctl()),     32'(g.ctl));
            chk("stall", 32'(stall_cycles),  32'(g.stall));
            chk("flush", 32'(flush_events),  32'(g.flush));
            chk("tmo",   32'(mem_timeout),   32'(g.tmo));
        end

        // advance model to the state after the coming edge
        if ((mw || (lu && !brt)) && m_stall < (1 << CW) - 1) m_stall++;
        if (brt && !mw && m_flush < (1 << CW) - 1) m_flush++;
        if (fr) begin
            m_wait = 0; m_cnt = 0; m_tmo = 1;
        end else if (mw) begin
            if (!m_wait) begin m_wait = 1; m_cnt = 1; end
            else m_cnt++;
        end else begin
            m_wait = 0; m_cnt = 0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        zero_inputs();
        model_reset();
        #2;
        chk("rst_ctl",   32'(dut_ctl()),    32'd0);
        chk("rst_stall", 32'(stall_cycles), 32'd0);
        chk("rst_flush", 32'(flush_events), 32'd0);
        chk("rst_tmo",   32'(mem_timeout),  32'd0);
        mem_Branch = 1; mem_zero = 1;
        #1;
        chk("rst_ctl_br", 32'(dut_ctl()), 32'd0);
        zero_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        idle(1);
        // load-use on rs1, then the bubble cycle
        step(5, 0, 1, 0, 5, 1, 0, 0, 0, 0);
        idle(1);
        chk("lu_stall_cnt", 32'(stall_cycles), 32'd1);
        // load into x0, unused rs2 match, used rs2 match
        step(0, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        step(3, 7, 1, 0, 7, 1, 0, 0, 0, 0);
        step(3, 7, 0, 1, 7, 1, 0, 0, 0, 0);
        idle(1);

        // taken branch, then not-taken
        step(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        idle(1);
        chk("br_flush_cnt", 32'(flush_events), 32'd1);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle(1);

        // memory wait: 3 cycles not ready, then ready
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(1);
        chk("mw_stall_cnt", 32'(stall_cycles), 32'd5);

        // priority: branch beats load-use; mem wait beats load-use and branch
        step(5, 0, 1, 0, 5, 1, 1, 1, 0, 0);
        step(5, 0, 1, 0, 5, 1, 0, 0, 1, 0);
        step(5, 0, 1, 0, 5, 1, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1, 1, 1, 1);
        idle(1);

        // timeout: held three cycles, fourth released, flag sticks
        for (int i = 0; i < MT; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(2);
        chk("tmo_sticky", 32'(mem_timeout), 32'd1);

        // reset asserted mid-WAIT
        for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_ctl",   32'(dut_ctl()),    32'd0);
        chk("arst_stall", 32'(stall_cycles), 32'd0);
        chk("arst_flush", 32'(flush_events), 32'd0);
        chk("arst_tmo",   32'(mem_timeout),  32'd0);
        model_reset();
        zero_inputs();
        @(negedge clk);
        rst = 1'b0;
        // a fresh access after reset must get the full wait budget
        for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(1);

        // saturation of the stall counter
        for (int i = 0; i < 20; i++) step(9, 0, 1, 0, 9, 1, 0, 0, 0, 0);
        idle(1);
        chk("stall_sat", 32'(stall_cycles), 32'd15);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
